// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a dual-port memory.
// Handshake: reqN is valid and gntN is ready; gntN may depend combinationally on the request, an access transfers in any cycle with reqN & gntN, and a denied requester keeps req/we/addr/wdata stable until it is granted.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
);
  logic                  req0;
  logic                  req1;
  logic                  we0_i;
  logic                  we1_i;
  logic [DATA_DEPTH-1:0] addr0_i;
  logic [DATA_DEPTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0_o;
  logic [DATA_WIDTH-1:0] rdata1_o;
  logic                  mem_we0;
  logic                  mem_we1;
  logic [DATA_DEPTH-1:0] mem_addr0;
  logic [DATA_DEPTH-1:0] mem_addr1;
  logic [DATA_WIDTH-1:0] mem_wdata0;
  logic [DATA_WIDTH-1:0] mem_wdata1;
  logic [DATA_WIDTH-1:0] mem_rdata0;
  logic [DATA_WIDTH-1:0] mem_rdata1;

  modport slave (
    input  req0, req1, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  mem_rdata0, mem_rdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0_o, rdata1_o,
    output mem_we0, mem_we1, mem_addr0, mem_addr1, mem_wdata0, mem_wdata1
  );

  modport master (
    output req0, req1, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output mem_rdata0, mem_rdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0_o, rdata1_o,
    input  mem_we0, mem_we1, mem_addr0, mem_addr1, mem_wdata0, mem_wdata1
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a dual-port memory: same-address accesses
// involving a write are serialised by a toggling priority pointer.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [7:0]        conflict_cnt,
  output logic              prio_dbg
);

  typedef enum logic {
    PRIO_PORT0 = 1'b0,
    PRIO_PORT1 = 1'b1
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  conflict;
  logic                  gnt0, gnt1;
  logic [DATA_DEPTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;

  assign addr0  = bus.addr0_i;
  assign addr1  = bus.addr1_i;
  assign wdata0 = bus.wdata0_i;
  assign wdata1 = bus.wdata1_i;

  // Two reads of the same word are harmless; only a write makes it a conflict.
  always_comb begin
    conflict = bus.req0 & bus.req1 & (addr0 == addr1) & (bus.we0_i | bus.we1_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= PRIO_PORT0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // The pointer moves to the loser so a held request wins on the next cycle.
  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (conflict) begin
      prio_d = (prio_q == PRIO_PORT0) ? PRIO_PORT1 : PRIO_PORT0;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    rvalid0_d = gnt0 & ~bus.we0_i;
    rvalid1_d = gnt1 & ~bus.we1_i;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = bus.req0 & (~conflict | (prio_q == PRIO_PORT0));
      gnt1 = bus.req1 & (~conflict | (prio_q == PRIO_PORT1));
    end
    bus.gnt0       = gnt0;
    bus.gnt1       = gnt1;
    bus.mem_we0    = gnt0 & bus.we0_i;
    bus.mem_we1    = gnt1 & bus.we1_i;
    bus.mem_addr0  = gnt0 ? addr0 : '0;
    bus.mem_addr1  = gnt1 ? addr1 : '0;
    bus.mem_wdata0 = gnt0 ? wdata0 : '0;
    bus.mem_wdata1 = gnt1 ? wdata1 : '0;
    bus.rvalid0    = rvalid0_q;
    bus.rvalid1    = rvalid1_q;
    bus.rdata0_o   = rvalid0_q ? bus.mem_rdata0 : '0;
    bus.rdata1_o   = rvalid1_q ? bus.mem_rdata1 : '0;
  end

  assign conflict_cnt = cnt_q;
  assign prio_dbg     = prio_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with a read-data queue per port.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [7:0] conflict_cnt;
  logic       prio_dbg;

  mem_port_arbiter_if #(.DATA_WIDTH(W), .DATA_DEPTH(D)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(W), .DATA_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus), .conflict_cnt(conflict_cnt), .prio_dbg(prio_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory behind the arbiter: synchronous write, one-cycle registered read
  logic [W-1:0] tb_mem [1<<D] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we0) tb_mem[bus.mem_addr0] <= bus.mem_wdata0;
    if (bus.mem_we1) tb_mem[bus.mem_addr1] <= bus.mem_wdata1;
    bus.mem_rdata0 <= tb_mem[bus.mem_addr0];
    bus.mem_rdata1 <= tb_mem[bus.mem_addr1];
  end

  // reference model state and scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  int           m_prio = 0;
  int           m_cnt = 0;
  logic [W-1:0] ref_mem [1<<D] = '{default: '0};
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic         e_conf, e_g0, e_g1, e_we0, e_we1, e_rv0, e_rv1;
  logic [D-1:0] e_a0, e_a1;
  logic [W-1:0] e_wd0, e_wd1, e_rd0, e_rd1;

  // driver tasks
  task automatic drive(input logic r0, input logic w0, input logic [D-1:0] a0, input logic [W-1:0] d0,
                       input logic r1, input logic w1, input logic [D-1:0] a1, input logic [W-1:0] d1);
    bus.req0 = r0; bus.we0_i = w0; bus.addr0_i = a0; bus.wdata0_i = d0;
    bus.req1 = r1; bus.we1_i = w1; bus.addr1_i = a1; bus.wdata1_i = d1;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_eval();
    e_conf = bus.req0 && bus.req1 && (bus.addr0_i == bus.addr1_i) && (bus.we0_i || bus.we1_i);
    e_g0   = bus.req0 && (!e_conf || m_prio == 0);
    e_g1   = bus.req1 && (!e_conf || m_prio == 1);
    e_we0  = e_g0 && bus.we0_i;
    e_we1  = e_g1 && bus.we1_i;
    e_a0   = e_g0 ? bus.addr0_i : '0;
    e_a1   = e_g1 ? bus.addr1_i : '0;
    e_wd0  = e_g0 ? bus.wdata0_i : '0;
    e_wd1  = e_g1 ? bus.wdata1_i : '0;
    e_rv0  = exp_q0.size() != 0;
    e_rv1  = exp_q1.size() != 0;
    e_rd0  = e_rv0 ? exp_q0[0] : '0;
    e_rd1  = e_rv1 ? exp_q1[0] : '0;
  endtask

  // advance one clock: retire last cycle's reads, then accept this cycle's accesses
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (exp_q0.size() != 0) void'(exp_q0.pop_front());
    if (exp_q1.size() != 0) void'(exp_q1.pop_front());
    if (e_g0 && !bus.we0_i) exp_q0.push_back(ref_mem[bus.addr0_i]);
    if (e_g1 && !bus.we1_i) exp_q1.push_back(ref_mem[bus.addr1_i]);
    if (e_g0 && bus.we0_i) ref_mem[bus.addr0_i] = bus.wdata0_i;
    if (e_g1 && bus.we1_i) ref_mem[bus.addr1_i] = bus.wdata1_i;
    if (e_conf) begin
      m_prio = 1 - m_prio;
      if (m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_cnt  = 0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 5, 16'h1111, 1, 1, 5, 16'h2222);
    @(negedge clk);
    n_vec++; if ({bus.gnt0, bus.gnt1, bus.mem_we0, bus.mem_we1} !== 4'b0) begin n_err++; $display("FAIL rst_gnt_we: got %b, expected 0000", {bus.gnt0, bus.gnt1, bus.mem_we0, bus.mem_we1}); end
    n_vec++; if ({bus.mem_addr0, bus.mem_addr1, bus.mem_wdata0, bus.mem_wdata1} !== '0) begin n_err++; $display("FAIL rst_addr_data: got %h %h %h %h, expected all 0", bus.mem_addr0, bus.mem_addr1, bus.mem_wdata0, bus.mem_wdata1); end
    n_vec++; if ({bus.rvalid0, bus.rvalid1} !== 2'b0) begin n_err++; $display("FAIL rst_rvalid: got %b, expected 00", {bus.rvalid0, bus.rvalid1}); end
    n_vec++; if (conflict_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d, expected 0", conflict_cnt); end
    n_vec++; if (prio_dbg !== 1'b0) begin n_err++; $display("FAIL rst_prio: got %b, expected 0", prio_dbg); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    model_reset();
  endtask

  task automatic test_write_read();
    drive(1, 1, 3, 16'hA5A5, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL wr_gnt0: got %b, expected 1", bus.gnt0); end
    n_vec++; if (bus.mem_wdata0 !== 16'hA5A5) begin n_err++; $display("FAIL wr_wdata0: got %h, expected a5a5", bus.mem_wdata0); end
    tick();
    drive(1, 0, 3, 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL rd_gnt0: got %b, expected 1", bus.gnt0); end
    n_vec++; if (bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b, expected 0", bus.rvalid0); end
    tick();
    drive_idle();
    @(negedge clk);
    n_vec++; if (bus.rvalid0 !== 1'b1) begin n_err++; $display("FAIL rd_rvalid0: got %b, expected 1", bus.rvalid0); end
    n_vec++; if (bus.rdata0_o !== 16'hA5A5) begin n_err++; $display("FAIL rd_rdata0: got %h, expected a5a5", bus.rdata0_o); end
    tick();
  endtask

  task automatic test_ww_conflict();
    do_reset();
    drive(1, 1, 5, 16'h1111, 1, 1, 5, 16'h2222);
    @(negedge clk);
    n_vec++; if ({bus.gnt0, bus.gnt1, bus.mem_we1} !== 3'b100) begin n_err++; $display("FAIL ww_c1: got gnt0/gnt1/mem_we1=%b, expected 100", {bus.gnt0, bus.gnt1, bus.mem_we1}); end
    n_vec++; if (bus.mem_addr1 !== 4'd0) begin n_err++; $display("FAIL ww_loser_addr: got %h, expected 0", bus.mem_addr1); end
    tick();
    @(negedge clk);
    n_vec++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_err++; $display("FAIL ww_c2: got gnt0/gnt1=%b, expected 01", {bus.gnt0, bus.gnt1}); end
    n_vec++; if (bus.mem_wdata1 !== 16'h2222) begin n_err++; $display("FAIL ww_wdata1: got %h, expected 2222", bus.mem_wdata1); end
    tick();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (conflict_cnt !== 8'd2) begin n_err++; $display("FAIL ww_cnt: got %0d, expected 2", conflict_cnt); end
    n_vec++; if (prio_dbg !== 1'b0) begin n_err++; $display("FAIL ww_prio: got %b, expected 0", prio_dbg); end
    tick();
    drive_idle();
    @(negedge clk);
    n_vec++; if (bus.rdata0_o !== 16'h2222 || bus.rvalid0 !== 1'b1) begin n_err++; $display("FAIL ww_final: got rvalid %b data %h, expected 1 2222", bus.rvalid0, bus.rdata0_o); end
    tick();
  endtask

  task automatic test_rw_prio();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 7, 16'h0777);
    tick();
    drive(1, 1, 2, 16'h0002, 1, 1, 2, 16'h0202);
    tick();
    drive(1, 1, 7, 16'hBEEF, 1, 0, 7, 0);
    @(negedge clk);
    n_vec++; if (prio_dbg !== 1'b1) begin n_err++; $display("FAIL rw_prio: got %b, expected 1", prio_dbg); end
    n_vec++; if ({bus.gnt0, bus.gnt1, bus.mem_we0} !== 3'b010) begin n_err++; $display("FAIL rw_grant: got gnt0/gnt1/mem_we0=%b, expected 010", {bus.gnt0, bus.gnt1, bus.mem_we0}); end
    tick();
    drive(1, 1, 7, 16'hBEEF, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL rw_gnt0_next: got %b, expected 1", bus.gnt0); end
    n_vec++; if (bus.rvalid1 !== 1'b1 || bus.rdata1_o !== 16'h0777) begin n_err++; $display("FAIL rw_old: got rvalid %b data %h, expected 1 0777", bus.rvalid1, bus.rdata1_o); end
    tick();
    drive(0, 0, 0, 0, 1, 0, 7, 0);
    tick();
    drive_idle();
    @(negedge clk);
    n_vec++; if (bus.rdata1_o !== 16'hBEEF) begin n_err++; $display("FAIL rw_new: got %h, expected beef", bus.rdata1_o); end
    tick();
  endtask

  task automatic test_rr_same();
    int c;
    drive(0, 0, 0, 0, 1, 1, 9, 16'h9999);
    tick();
    c = m_cnt;
    drive(1, 0, 9, 0, 1, 0, 9, 0);
    @(negedge clk);
    n_vec++; if ({bus.gnt0, bus.gnt1} !== 2'b11) begin n_err++; $display("FAIL rr_gnt: got %b, expected 11", {bus.gnt0, bus.gnt1}); end
    tick();
    drive_idle();
    @(negedge clk);
    n_vec++; if (conflict_cnt !== c[7:0]) begin n_err++; $display("FAIL rr_cnt: got %0d, expected %0d", conflict_cnt, c); end
    n_vec++; if ({bus.rvalid0, bus.rvalid1} !== 2'b11) begin n_err++; $display("FAIL rr_rvalid: got %b, expected 11", {bus.rvalid0, bus.rvalid1}); end
    n_vec++; if (bus.rdata0_o !== 16'h9999 || bus.rdata1_o !== 16'h9999) begin n_err++; $display("FAIL rr_data: got %h %h, expected 9999 9999", bus.rdata0_o, bus.rdata1_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, i[D-1:0], 0, 1, 1, 4'(8 + i), W'($urandom));
      @(negedge clk);
      model_eval();
      if (i > 0) begin
        n_vec++; if (bus.rvalid0 !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid[%0d]: got %b, expected 1", i, bus.rvalid0); end
        n_vec++; if (bus.rdata0_o !== e_rd0) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h, expected %h", i, bus.rdata0_o, e_rd0); end
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 1, 1, 16'h00AA, 1, 1, 1, 16'h00BB);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_vec++; if (bus.gnt0 !== (i % 2 == 0)) begin n_err++; $display("FAIL sat_gnt0[%0d]: got %b, expected %b", i, bus.gnt0, (i % 2 == 0)); end
      n_vec++; if (bus.gnt1 !== (i % 2 == 1)) begin n_err++; $display("FAIL sat_gnt1[%0d]: got %b, expected %b", i, bus.gnt1, (i % 2 == 1)); end
      tick();
    end
    drive_idle();
    @(negedge clk);
    n_vec++; if (conflict_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d, expected 255", conflict_cnt); end
    tick();
  endtask

  task automatic test_random();
    logic hold0, hold1;
    logic r0, w0, r1, w1;
    logic [D-1:0] a0, a1;
    logic [W-1:0] d0, d1;
    hold0 = 0; hold1 = 0;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; r1 = 0; w1 = 0; a1 = 0; d1 = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (!hold0) begin
        r0 = $urandom_range(0, 3) != 0; w0 = 1'($urandom_range(0, 1));
        a0 = D'($urandom_range(0, 3)); d0 = W'($urandom);
      end
      if (!hold1) begin
        r1 = $urandom_range(0, 3) != 0; w1 = 1'($urandom_range(0, 1));
        a1 = D'($urandom_range(0, 3)); d1 = W'($urandom);
      end
      drive(r0, w0, a0, d0, r1, w1, a1, d1);
      @(negedge clk);
      model_eval();
      n_vec++; if ({bus.gnt0, bus.gnt1} !== {e_g0, e_g1}) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b, expected %b", i, {bus.gnt0, bus.gnt1}, {e_g0, e_g1}); end
      n_vec++; if ({bus.mem_we0, bus.mem_we1} !== {e_we0, e_we1}) begin n_err++; $display("FAIL rnd_we[%0d]: got %b, expected %b", i, {bus.mem_we0, bus.mem_we1}, {e_we0, e_we1}); end
      n_vec++; if ({bus.mem_addr0, bus.mem_addr1} !== {e_a0, e_a1}) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h %h, expected %h %h", i, bus.mem_addr0, bus.mem_addr1, e_a0, e_a1); end
      n_vec++; if ({bus.mem_wdata0, bus.mem_wdata1} !== {e_wd0, e_wd1}) begin n_err++; $display("FAIL rnd_wdata[%0d]: got %h %h, expected %h %h", i, bus.mem_wdata0, bus.mem_wdata1, e_wd0, e_wd1); end
      n_vec++; if ({bus.rvalid0, bus.rvalid1} !== {e_rv0, e_rv1}) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b, expected %b", i, {bus.rvalid0, bus.rvalid1}, {e_rv0, e_rv1}); end
      if (e_rv0) begin
        n_vec++; if (bus.rdata0_o !== e_rd0) begin n_err++; $display("FAIL rnd_rdata0[%0d]: got %h, expected %h", i, bus.rdata0_o, e_rd0); end
      end
      if (e_rv1) begin
        n_vec++; if (bus.rdata1_o !== e_rd1) begin n_err++; $display("FAIL rnd_rdata1[%0d]: got %h, expected %h", i, bus.rdata1_o, e_rd1); end
      end
      n_vec++; if (conflict_cnt !== m_cnt[7:0]) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d, expected %0d", i, conflict_cnt, m_cnt); end
      n_vec++; if (prio_dbg !== m_prio[0]) begin n_err++; $display("FAIL rnd_prio[%0d]: got %b, expected %0d", i, prio_dbg, m_prio); end
      hold0 = r0 && !e_g0;
      hold1 = r1 && !e_g1;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 4, 16'h4444, 1, 1, 4, 16'h5555);
    tick();
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (bus.rvalid0 !== 1'b1) begin n_err++; $display("FAIL mid_rvalid_before: got %b, expected 1", bus.rvalid0); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL mid_rvalid_async: got %b, expected 0", bus.rvalid0); end
    n_vec++; if (bus.gnt0 !== 1'b0 || bus.mem_addr0 !== 4'd0) begin n_err++; $display("FAIL mid_gnt: got gnt0 %b addr %h, expected 0 0", bus.gnt0, bus.mem_addr0); end
    n_vec++; if (conflict_cnt !== 8'd0 || prio_dbg !== 1'b0) begin n_err++; $display("FAIL mid_state: got cnt %0d prio %b, expected 0 0", conflict_cnt, prio_dbg); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL mid_resume: got %b, expected 1", bus.gnt0); end
    tick();
    drive_idle();
    @(negedge clk);
    n_vec++; if (bus.rvalid0 !== 1'b1 || bus.rdata0_o !== 16'h4444) begin n_err++; $display("FAIL mid_read: got rvalid %b data %h, expected 1 4444", bus.rvalid0, bus.rdata0_o); end
    tick();
  endtask

  // sequence and final report
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_write_read();
    test_ww_conflict();
    test_rw_prio();
    test_rr_same();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
